// File: rtl/shift_left_seq_pkg.sv
// shift_left_seq_pkg: shared width, counter width and FSM state encoding for the sequential left shifter
package shift_left_seq_pkg;
  localparam int WIDTH = 32;
  localparam int CNTW = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_left_seq_ctrl.sv
// shift_left_seq_ctrl: FSM and shift counter; ports clk, rst, start, y in; load, step, fin (entering DONE), busy, done out
module shift_left_seq_ctrl #(
  parameter int WIDTH = shift_left_seq_pkg::WIDTH,
  parameter int CNTW = shift_left_seq_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  output logic             load,
  output logic             step,
  output logic             fin,
  output logic             busy,
  output logic             done
);
  import shift_left_seq_pkg::*;
  localparam int SW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CNTW-1:0] cnt, cnt_ld;
  always_comb begin
    cnt_ld = |y[WIDTH-1:SW] ? CNTW'(WIDTH) : CNTW'(y[SW-1:0]);
    load = state == IDLE && start;
    step = state == SHIFT;
    state_nx = load ? (cnt_ld != '0 ? SHIFT : DONE) : step ? (cnt == CNTW'(1) ? DONE : SHIFT) : IDLE;
    fin = state_nx == DONE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= load ? cnt_ld : step ? cnt - CNTW'(1) : cnt;
    end
  end
endmodule

// File: rtl/shift_left_seq.sv
// shift_left_seq: one-bit-per-clock logical left shifter; ports clk, rst, start, X, Y in; Z, V, busy, done out
module shift_left_seq #(
  parameter int WIDTH = shift_left_seq_pkg::WIDTH,
  parameter int CNTW = shift_left_seq_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             V,
  output logic             busy,
  output logic             done
);
  import shift_left_seq_pkg::*;
  logic load, step, fin, vacc, vacc_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  shift_left_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .y(Y),
    .load(load), .step(step), .fin(fin), .busy(busy), .done(done)
  );
  always_comb begin
    acc_nx = load ? X : step ? {acc[WIDTH-2:0], 1'b0} : acc;
    vacc_nx = load ? 1'b0 : step ? vacc | acc[WIDTH-1] : vacc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      vacc <= 1'b0;
      Z <= '0;
      V <= 1'b0;
    end else begin
      acc <= acc_nx;
      vacc <= vacc_nx;
      if (fin) begin
        Z <= acc_nx;
        V <= vacc_nx;
      end
    end
  end
endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: table-driven and directed checks of shift_left_seq results, latency, handshake and reset
module tb_shift_left_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, V, busy, done;
  logic [31:0] X = '0, Y = '0, Z;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] x, y, z; logic v; int lat;} vec_t;
  vec_t tv[15];
  shift_left_seq dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .Z(Z), .V(V), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_done(output int n, output int nb, output bit hold, input logic [31:0] z0);
    n = 0;
    nb = 0;
    hold = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) break;
      if (Z !== z0) hold = 1'b0;
    end
  endtask
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ez,
                        input logic ev, input int lat, input string nm);
    int n, nb;
    bit hold;
    logic [31:0] z0;
    @(negedge clk);
    X = x;
    Y = y;
    start = 1'b1;
    z0 = Z;
    @(posedge clk);
    #1;
    start = 1'b0;
    X = $urandom;
    Y = $urandom;
    wait_done(n, nb, hold, z0);
    check({nm, " latency"}, n, lat);
    check({nm, " busy cycles"}, nb, lat);
    check({nm, " Z"}, Z, ez);
    check({nm, " V"}, {31'b0, V}, {31'b0, ev});
    check({nm, " Z hold"}, {31'b0, hold}, 32'd1);
    @(negedge clk);
    check({nm, " after done busy/done"}, {30'b0, busy, done}, 32'd0);
  endtask
  initial begin
    int n, nb, seen;
    bit hold;
    tv[0]  = '{32'h0000000A, 32'd0,        32'h0000000A, 1'b0, 1};
    tv[1]  = '{32'h0000000A, 32'd2,        32'h00000028, 1'b0, 3};
    tv[2]  = '{32'h80000001, 32'd1,        32'h00000002, 1'b1, 2};
    tv[3]  = '{32'h0000000A, 32'hFFFFFFFF, 32'h00000000, 1'b1, 33};
    tv[4]  = '{32'h0000000A, 32'h7FFFFFFF, 32'h00000000, 1'b1, 33};
    tv[5]  = '{32'h0000000A, 32'd35,       32'h00000000, 1'b1, 33};
    tv[6]  = '{32'h00000000, 32'd40,       32'h00000000, 1'b0, 33};
    tv[7]  = '{32'h00000001, 32'd31,       32'h80000000, 1'b0, 32};
    tv[8]  = '{32'h00000003, 32'd31,       32'h80000000, 1'b1, 32};
    tv[9]  = '{32'hFFFFFFFF, 32'd4,        32'hFFFFFFF0, 1'b1, 5};
    tv[10] = '{32'h0F000000, 32'd4,        32'hF0000000, 1'b0, 5};
    tv[11] = '{32'h0F000000, 32'd5,        32'hE0000000, 1'b1, 6};
    tv[12] = '{32'h12345678, 32'd32,       32'h00000000, 1'b1, 33};
    tv[13] = '{32'h12345678, 32'd8,        32'h34567800, 1'b1, 9};
    tv[14] = '{32'h00345678, 32'd8,        32'h34567800, 1'b0, 9};
    X = 32'hDEADBEEF;
    Y = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset Z", Z, 32'd0);
    check("reset V/busy/done", {29'b0, V, busy, done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) run_op(tv[i].x, tv[i].y, tv[i].z, tv[i].v, tv[i].lat, $sformatf("vec%0d", i));
    @(negedge clk);
    X = 32'h5;
    Y = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    X = 32'hFFFF;
    Y = 32'd4;
    wait_done(n, nb, hold, 32'h34567800);
    check("ignore latency", n, 4);
    check("ignore Z", Z, 32'h28);
    check("ignore V", {31'b0, V}, 32'd0);
    check("ignore Z hold", {31'b0, hold}, 32'd1);
    @(negedge clk);
    check("start in DONE ignored busy", {31'b0, busy}, 32'd0);
    check("start in DONE ignored Z", Z, 32'h28);
    start = 1'b0;
    run_op(32'hFFFF, 32'd4, 32'h000FFFF0, 1'b0, 5, "post-ignore");
    @(negedge clk);
    X = 32'h3;
    Y = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort Z", Z, 32'd0);
    check("abort V/busy/done", {29'b0, V, busy, done}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort no done", seen, 0);
    run_op(32'h1, 32'd31, 32'h80000000, 1'b0, 32, "after abort");
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    X = 32'h7;
    Y = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("rst over start busy/done", {30'b0, busy, done}, 32'd0);
    check("rst over start Z", Z, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
